// File: rtl/ex_muldiv_ctrl.sv
// Iterative EX-stage mul/div unit (MUL, MULHU, DIVU, REMU): 34 EX cycles for MUL/DIV, 2 for divide-by-zero.
// Stalls F/D/E while an op is in flight; FlushE aborts the op at once, and the pipeline advances in the DONE cycle.
module ex_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        MulDivE,
  input  logic [1:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        StallMD,
  output logic        BusyMD,
  output logic        DoneMD,
  output logic [31:0] ResultMD
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        opsel_q, opsel_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] result_q, result_d;

  logic [32:0] mul_sum;
  logic [63:0] prod_step;
  logic [32:0] rem_shift;
  logic        div_ge;
  logic [31:0] rem_step;
  logic [31:0] quot_step;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opsel_d  = opsel_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    result_d = result_q;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
    prod_step = {mul_sum, prod_q[31:1]};

    // Restoring divide; a 32-bit subtract suffices because the result is below the divisor.
    rem_shift = {rem_q, quot_q[31]};
    div_ge    = rem_shift >= {1'b0, b_q};
    rem_step  = div_ge ? (rem_shift[31:0] - b_q) : rem_shift[31:0];
    quot_step = {quot_q[30:0], div_ge};

    unique case (state_q)
      IDLE: begin
        if (MulDivE) begin
          cnt_d   = 6'd0;
          opsel_d = MulDivOpE[0];
          a_d     = SrcAE;
          b_d     = SrcBE;
          if (!MulDivOpE[1]) begin
            prod_d  = {32'd0, SrcBE};
            state_d = MUL;
          end else if (SrcBE != 32'd0) begin
            quot_d  = SrcAE;
            rem_d   = 32'd0;
            state_d = DIV;
          end else begin
            quot_d   = 32'hFFFF_FFFF;
            rem_d    = SrcAE;
            result_d = MulDivOpE[0] ? SrcAE : 32'hFFFF_FFFF;
            state_d  = DONE;
          end
        end
      end
      MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          result_d = opsel_q ? prod_step[63:32] : prod_step[31:0];
          state_d  = DONE;
        end
      end
      DIV: begin
        rem_d  = rem_step;
        quot_d = quot_step;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          result_d = opsel_q ? rem_step : quot_step;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (FlushE) begin
      state_d  = IDLE;
      cnt_d    = 6'd0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      opsel_q  <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      prod_q   <= 64'd0;
      quot_q   <= 32'd0;
      rem_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opsel_q  <= opsel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  // The DONE cycle releases the stall so EX/MEM captures ResultMD.
  assign StallMD  = rst && MulDivE && (state_q != DONE) && !FlushE;
  assign BusyMD   = (state_q != IDLE);
  assign DoneMD   = (state_q == DONE);
  assign ResultMD = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: directed literal cases plus a randomized pipeline driver,
// all checked every cycle against a cycle-count/arithmetic model of the unit.
module tb_ex_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        MulDivE;
  logic [1:0]  MulDivOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        StallMD;
  logic        BusyMD;
  logic        DoneMD;
  logic [31:0] ResultMD;

  ex_muldiv_ctrl dut (
    .clk(clk), .rst(rst), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .StallMD(StallMD), .BusyMD(BusyMD), .DoneMD(DoneMD), .ResultMD(ResultMD)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;
  bit last_exp_stall = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model: an accepted op completes a fixed number of cycles later with its arithmetic result.
  int          m_left = 0;
  bit          m_done = 0;
  logic [31:0] m_res  = 32'd0;
  logic [31:0] m_pend = 32'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0;
      m_done <= 0;
      m_res  <= 32'd0;
    end else if (FlushE) begin
      m_left <= 0;
      m_done <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1;
        m_res  <= m_pend;
      end
    end else if (MulDivE) begin
      if (MulDivOpE[1] && SrcBE == 32'd0) begin
        m_done <= 1;
        m_res  <= ref_op(MulDivOpE, SrcAE, SrcBE);
      end else begin
        m_left <= 32;
        m_pend <= ref_op(MulDivOpE, SrcAE, SrcBE);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      last_exp_stall = rst && MulDivE && !m_done && !FlushE;
      chk("stall", 32'(StallMD), 32'(last_exp_stall));
      chk("busy",  32'(BusyMD),  32'((m_left > 0) || m_done));
      chk("done",  32'(DoneMD),  32'(m_done));
      chk("result", ResultMD, m_res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit tog, input string nm,
                        output int start_c, output int done_c);
    int n;
    int stalls;
    MulDivE   = 1;
    MulDivOpE = op;
    SrcAE     = a;
    SrcBE     = b;
    start_c   = cyc;
    stalls    = 0;
    for (n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (DoneMD) break;
      if (StallMD) stalls++;
      step();
      if (tog) begin
        SrcAE     = $urandom;
        SrcBE     = $urandom;
        MulDivOpE = 2'($urandom);
      end
    end
    done_c = cyc;
    if (n > 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: no DoneMD within 40 cycles", nm);
    end else begin
      chk({nm, "_lat"}, 32'(n), 32'(lat));
      chk({nm, "_stalls"}, 32'(stalls), 32'(lat));
      chk({nm, "_res"}, ResultMD, exp);
      chk({nm, "_model"}, m_res, exp);
    end
    step();
    MulDivE = 0;
  endtask

  task automatic expect_no_done(input string nm);
    bit seen;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneMD) seen = 1;
    end
    chk(nm, 32'(seen), 32'd0);
    step();
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom % 4)
      0:       return 32'd0;
      1:       return $urandom % 16;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, s1, d1;
    rst = 1; MulDivE = 1; MulDivOpE = 0; SrcAE = 0; SrcBE = 0; FlushE = 0;
    #1 rst = 0;
    #1;
    chk("rst_stall", 32'(StallMD), 32'd0);
    chk("rst_busy",  32'(BusyMD),  32'd0);
    chk("rst_done",  32'(DoneMD),  32'd0);
    chk("rst_result", ResultMD, 32'd0);
    chk_en = 1;
    MulDivE = 0;
    step(); step();
    rst = 1;
    step();

    run_op(2'd0, 32'h7, 32'h6, 32'h0000_002A, 33, 0, "mul", s0, d0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, "mulhu", s0, d0);
    run_op(2'd2, 32'd100, 32'd7, 32'h0000_000E, 33, 0, "divu", s0, d0);
    run_op(2'd3, 32'd100, 32'd7, 32'h0000_0002, 33, 0, "remu", s0, d0);
    run_op(2'd2, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 0, "divz", s0, d0);
    run_op(2'd3, 32'h1234, 32'd0, 32'h0000_1234, 1, 0, "remz", s0, d0);

    // Back-to-back with operands scrambled while busy.
    run_op(2'd0, 32'h0001_0003, 32'h0000_0101, 32'h0101_0303, 33, 1, "b2b0", s0, d0);
    run_op(2'd0, 32'h0000_0300, 32'h0000_0011, 32'h0000_3300, 33, 1, "b2b1", s1, d1);
    chk("b2b_second_done", 32'(d1 - s0), 32'd67);

    // Flush at T+10 of a DIVU.
    MulDivE = 1; MulDivOpE = 2'd2; SrcAE = 32'd1000; SrcBE = 32'd3;
    repeat (10) step();
    FlushE = 1;
    @(negedge clk);
    chk("flush_stall", 32'(StallMD), 32'd0);
    step();
    FlushE = 0; MulDivE = 0;
    @(negedge clk);
    chk("flush_busy", 32'(BusyMD), 32'd0);
    expect_no_done("flush_nodone");

    // Reset asserted at T+5 of a MUL.
    MulDivE = 1; MulDivOpE = 2'd0; SrcAE = 32'h55; SrcBE = 32'h3;
    repeat (5) step();
    rst = 0;
    #1;
    chk("arst_busy",  32'(BusyMD),  32'd0);
    chk("arst_done",  32'(DoneMD),  32'd0);
    chk("arst_stall", 32'(StallMD), 32'd0);
    chk("arst_result", ResultMD, 32'd0);
    step(); step();
    rst = 1; MulDivE = 0;
    expect_no_done("arst_nodone");
    run_op(2'd0, 32'd3, 32'd5, 32'd15, 33, 0, "resume", s0, d0);

    // Randomized pipeline: an op stays in EX while the model says it stalls.
    for (int i = 0; i < 3000; i++) begin
      if (last_exp_stall) begin
        MulDivE = 1;
        if ($urandom % 4 == 0) begin
          SrcAE = $urandom; SrcBE = $urandom; MulDivOpE = 2'($urandom);
        end
      end else begin
        MulDivE   = ($urandom % 3 == 0);
        MulDivOpE = 2'($urandom);
        SrcAE     = rnd_opnd();
        SrcBE     = rnd_opnd();
      end
      FlushE = ($urandom % 60 == 0);
      step();
    end
    FlushE = 0; MulDivE = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst (active-low, asynchronous assert, synchronous release).
REQ-002 The block SHALL have these ports:
- clk  in  1  pipeline clock.
- rst  in  1  async active-low reset.
- MulDivE  in  1  the instruction in EX is a mul/div op.
- MulDivOpE  in  2  operation select: 00 MUL (low 32 bits), 01 MULHU (high 32 bits, unsigned), 10 DIVU, 11 REMU.
- SrcAE  in  32  forwarded operand A.
- SrcBE  in  32  forwarded operand B.
- FlushE  in  1  kills the EX instruction.
- StallMD  out  1  holds the F, D and E pipeline registers and inserts a bubble into MEM.
- BusyMD  out  1  FSM is not in IDLE.
- DoneMD  out  1  single-cycle pulse: ResultMD is valid.
- ResultMD  out  32  operation result, muxed into ALUResultE by the EX stage when DoneMD=1.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, MUL, DIV, DONE.
REQ-004 In IDLE with MulDivE=1 and FlushE=0, the block SHALL latch SrcAE, SrcBE and MulDivOpE, clear the iteration counter, and move to:
- MUL for op 0x;
- DIV for op 1x with SrcBE≠0;
- DONE for op 1x with SrcBE=0.
REQ-005 MUL SHALL run a shift-add over a 64-bit product register, one multiplier bit per cycle, for exactly 32 cycles, then move to DONE.
REQ-006 DIV SHALL run a restoring divide with a 32-bit remainder and 32-bit quotient, one quotient bit per cycle, for exactly 32 cycles, then move to DONE.
REQ-007 The iteration counter SHALL be 6 bits wide and terminate at count 31; there SHALL be no early exit for zero or small operands.
REQ-008 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-009 StallMD SHALL be combinational and equal MulDivE AND (state≠DONE) AND NOT FlushE.
REQ-010 In the start cycle, StallMD SHALL be 1 so that the op stays in EX.
REQ-011 The pipeline SHALL advance in the DONE cycle, and the EX/MEM register SHALL capture ResultMD in that cycle.
REQ-012 Latency SHALL be fixed:
- start cycle T, DONE cycle T+33 for MUL/DIV (34 EX cycles total);
- DONE cycle T+1 for divide-by-zero.
REQ-013 DoneMD SHALL be 1 only in DONE.
REQ-014 ResultMD SHALL hold its last value outside DONE.
REQ-015 ResultMD SHALL be selected as follows:
- MUL: product[31:0];
- MULHU: product[63:32];
- DIVU: quotient;
- REMU: remainder.
REQ-016 Division by zero SHALL give quotient 0xFFFFFFFF and remainder equal to the dividend (RISC-V semantics).
REQ-017 All arithmetic SHALL be unsigned and modulo 2^32/2^64, with no overflow flag.
REQ-018 Changes on SrcAE, SrcBE or MulDivOpE while BusyMD=1 SHALL be ignored, because the operands are latched.
REQ-019 FlushE=1 SHALL have priority over start and over every state:
- the next state is IDLE;
- no DoneMD pulse is produced;
- StallMD is 0 in that cycle.
REQ-020 A new MulDivE in the cycle after DONE (back-to-back ops) SHALL start a new operation from IDLE with no extra bubble.
REQ-021 MulDivE=0 in IDLE SHALL leave the state unchanged, with StallMD=0.

Reset
REQ-022 When rst=0, the block SHALL asynchronously force:
- state to IDLE and the counter to 0;
- BusyMD=0 and DoneMD=0;
- ResultMD to 0x00000000;
- the product, quotient and remainder registers to 0.
REQ-023 StallMD SHALL read 0 while rst=0.
REQ-024 Reset mid-operation SHALL abort the operation with no DoneMD pulse, and normal operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-025 MUL test: MUL with A=0x0000_0007, B=0x0000_0006 at cycle T -> StallMD=1 for T..T+32, DoneMD=1 and ResultMD=0x0000_002A at T+33.
REQ-026 MULHU test: MULHU with A=B=0xFFFF_FFFF -> ResultMD=0xFFFF_FFFE at T+33.
REQ-027 DIVU/REMU test: DIVU with 100/7 -> 0x0000_000E; REMU with 100/7 -> 0x0000_0002; both at T+33.
REQ-028 Divide-by-zero test: DIVU with 0x1234/0 -> DoneMD at T+1, ResultMD=0xFFFF_FFFF; REMU with 0x1234/0 -> 0x0000_1234.
REQ-029 Flush test: FlushE=1 at T+10 of a DIVU -> BusyMD=0 at T+11, no DoneMD pulse; rst=0 pulsed at T+5 of a MUL -> all outputs reset immediately.
REQ-030 Back-to-back test: two MULs back to back, with operand inputs toggled mid-operation -> DoneMD at T+33 and T+67, each with the result of its own latched operands.
